// File: rtl/tile_board_ctrl_if.sv
// tile_board_ctrl_if: input-logic/checker side bus of the tic-tac-toe move controller
interface tile_board_ctrl_if;
    logic        new_game;
    logic [3:0]  sel;
    logic        place;
    logic        game_over;
    logic [17:0] tiles;
    logic [1:0]  turn;
    logic [3:0]  move_count;
    logic        illegal;
    logic        draw;
    logic        busy;
    modport master (output new_game, sel, place, game_over,
                    input tiles, turn, move_count, illegal, draw, busy);
    modport slave  (input new_game, sel, place, game_over,
                    output tiles, turn, move_count, illegal, draw, busy);
endinterface

// File: rtl/tile_board_ctrl.sv
// tile_board_ctrl: owns the 3x3 board, alternates turns, rejects illegal moves, locks on win/draw
module tile_board_ctrl #(
    parameter logic [1:0] FIRST_MARK = 2'b01,
    parameter int         SETTLE_CYC = 2
) (
    input logic           clk,
    input logic           reset,
    tile_board_ctrl_if.slave bus
);
    localparam logic [1:0] READY  = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int CW = $clog2(SETTLE_CYC + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [17:0]   tiles;
    logic [1:0]    turn;
    logic [3:0]    move_count;
    logic          illegal;
    logic          draw;
    logic [1:0]    cur;
    logic          legal;

    // padding keeps the lookup in range for the illegal sel values 9..15
    assign cur   = 2'({14'd0, tiles} >> {bus.sel, 1'b0});
    assign legal = bus.sel <= 4'd8 && cur == 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            cnt        <= '0;
            tiles      <= '0;
            turn       <= FIRST_MARK;
            move_count <= '0;
            illegal    <= 1'b0;
            draw       <= 1'b0;
        end else if (bus.new_game) begin
            state      <= HOLD;
            cnt        <= '0;
            tiles      <= '0;
            turn       <= FIRST_MARK;
            move_count <= '0;
            illegal    <= 1'b0;
            draw       <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                READY: begin
                    if (bus.game_over) begin
                        state <= DONE;
                    end else if (bus.place && legal) begin
                        tiles      <= tiles | (18'(turn) << {bus.sel, 1'b0});
                        turn       <= ~turn;
                        move_count <= move_count == 4'd9 ? 4'd9 : move_count + 4'd1;
                        cnt        <= '0;
                        state      <= SETTLE;
                    end else if (bus.place) begin
                        illegal <= 1'b1;
                        state   <= HOLD;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    // game_over lags the board, so it is only trusted once settled
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        if (bus.game_over) begin
                            state <= DONE;
                        end else if (move_count == 4'd9) begin
                            state <= DONE;
                            draw  <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: state <= bus.place ? HOLD : READY;
                default: state <= DONE;
            endcase
        end
    end

    assign bus.tiles      = tiles;
    assign bus.turn       = turn;
    assign bus.move_count = move_count;
    assign bus.illegal    = illegal;
    assign bus.draw       = draw;
    assign bus.busy       = state != READY;
endmodule

// File: tb/tb_tile_board_ctrl.sv
// tb_tile_board_ctrl: directed moves with a scoreboard of expected board events checked by a monitor
module tb_tile_board_ctrl;
    typedef struct {
        logic        ill;
        logic [17:0] t;
        logic [1:0]  tr;
        logic [3:0]  c;
    } ev_t;

    logic clk = 0;
    logic reset = 1;
    logic ng_s = 0;
    int n_chk = 0;
    int n_fail = 0;
    ev_t q[$];
    logic [17:0] mt;
    logic [1:0]  mturn;
    logic [3:0]  mcnt;
    logic        mdone;
    logic [17:0] prev_t;
    logic [3:0]  prev_c;

    tile_board_ctrl_if bus();
    tile_board_ctrl #(.FIRST_MARK(2'b01), .SETTLE_CYC(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) ng_s <= bus.new_game;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: any illegal pulse or board/count change is an event that must match the queue head
    always @(negedge clk) begin
        if (!(reset || ng_s) && (bus.illegal || bus.tiles != prev_t || bus.move_count != prev_c)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event actual tiles=%h illegal=%b count=%0d required=none",
                         bus.tiles, bus.illegal, bus.move_count);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_illegal", 32'(bus.illegal), 32'(e.ill));
                chk("ev_tiles", 32'(bus.tiles), 32'(e.t));
                chk("ev_turn", 32'(bus.turn), 32'(e.tr));
                chk("ev_count", 32'(bus.move_count), 32'(e.c));
            end
        end
        prev_t = bus.tiles;
        prev_c = bus.move_count;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mt = '0;
        mturn = 2'b01;
        mcnt = '0;
        mdone = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        chk("ready_wait", 32'(bus.busy), 0);
    endtask

    task automatic press(input logic [3:0] s, input int hold, input logic go);
        ev_t e;
        logic occ;
        logic commit;
        commit = 1'b0;
        if (!mdone) wait_ready();
        bus.sel = s;
        bus.place = 1'b1;
        if (!mdone) begin
            occ = (s <= 4'd8) ? (2'(mt >> (2 * s)) != 2'b00) : 1'b1;
            if (occ) begin
                e = '{1'b1, mt, mturn, mcnt};
            end else begin
                mt = mt | (18'(mturn) << (2 * s));
                mturn = ~mturn;
                mcnt = mcnt + 4'd1;
                commit = 1'b1;
                e = '{1'b0, mt, mturn, mcnt};
            end
            q.push_back(e);
        end
        tick();
        if (go) bus.game_over = 1'b1;
        if (commit && (go || mcnt == 4'd9)) mdone = 1'b1;
        for (int i = 1; i < hold; i++) tick();
        bus.place = 1'b0;
        repeat (4) tick();
    endtask

    task automatic new_game();
        bus.new_game = 1'b1;
        bus.game_over = 1'b0;
        tick();
        bus.new_game = 1'b0;
        model_clear();
        repeat (2) tick();
    endtask

    initial begin
        bus.new_game = 0;
        bus.sel = 0;
        bus.place = 0;
        bus.game_over = 0;
        model_clear();
        repeat (3) tick();
        chk("rst_tiles", 32'(bus.tiles), 0);
        chk("rst_turn", 32'(bus.turn), 32'h1);
        chk("rst_count", 32'(bus.move_count), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_draw", 32'(bus.draw), 0);
        chk("rst_busy", 32'(bus.busy), 1);
        reset = 0;
        repeat (2) tick();

        // X wins top row: X 0,1,2 / O 3,4
        press(0, 1, 0);
        press(3, 1, 0);
        press(1, 1, 0);
        press(4, 1, 0);
        press(2, 1, 1);
        chk("win_tiles", 32'(bus.tiles), 32'h00295);
        chk("win_draw", 32'(bus.draw), 0);
        chk("win_busy", 32'(bus.busy), 1);
        press(5, 1, 0);
        chk("done_ignore_tiles", 32'(bus.tiles), 32'h00295);
        chk("done_ignore_count", 32'(bus.move_count), 5);

        new_game();
        press(4, 1, 0);
        press(4, 1, 0);
        chk("occ_turn", 32'(bus.turn), 32'h2);
        chk("occ_count", 32'(bus.move_count), 1);
        press(9, 1, 0);
        press(15, 3, 0);
        chk("sel_hi_tiles", 32'(bus.tiles), 32'h00100);
        press(0, 20, 0);
        chk("long_hold_count", 32'(bus.move_count), 2);
        chk("long_hold_tiles", 32'(bus.tiles), 32'h00102);

        new_game();
        press(0, 1, 0);
        press(1, 1, 0);
        press(2, 1, 0);
        press(4, 1, 0);
        press(3, 1, 0);
        press(5, 1, 0);
        press(7, 1, 0);
        press(6, 1, 0);
        press(8, 1, 0);
        chk("draw_flag", 32'(bus.draw), 1);
        chk("draw_count", 32'(bus.move_count), 9);
        chk("draw_tiles", 32'(bus.tiles), 32'h16A59);
        chk("draw_busy", 32'(bus.busy), 1);
        press(0, 2, 0);
        chk("draw_ignore_count", 32'(bus.move_count), 9);

        bus.place = 1'b1;
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        model_clear();
        repeat (3) tick();
        chk("ng_tiles", 32'(bus.tiles), 0);
        chk("ng_turn", 32'(bus.turn), 32'h1);
        chk("ng_draw", 32'(bus.draw), 0);
        chk("ng_count", 32'(bus.move_count), 0);
        chk("ng_busy_held", 32'(bus.busy), 1);
        bus.place = 1'b0;
        tick();
        chk("ng_ready", 32'(bus.busy), 0);

        bus.sel = 4'd7;
        bus.place = 1'b1;
        tick();
        bus.place = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midsettle_tiles", 32'(bus.tiles), 0);
        chk("midsettle_count", 32'(bus.move_count), 0);
        chk("midsettle_turn", 32'(bus.turn), 32'h1);
        chk("midsettle_busy", 32'(bus.busy), 1);
        repeat (2) tick();
        chk("midsettle_ready", 32'(bus.busy), 0);

        repeat (3) tick();
        chk("pending_events", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
